// File: rtl/ram_stream_reader.sv
// Read-side controller for the packet buffer: drains committed RAM entries into a
// valid/ready stream through a 2-entry head/skid buffer, returning the consumed pointer.
module ram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         fetch_ptr_q, fetch_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  pop;
    logic                  issue;
    logic [2:0]            pending;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign address_b = fetch_ptr_q[ADDR_WIDTH-1:0];
    assign rd_ptr    = rd_ptr_q;
    assign level     = wr_ptr - rd_ptr_q;
    assign empty     = (level == '0);

    assign pop = out_valid & out_ready;
    // Slots still claimed after this cycle; a pop implies occ >= 1, so no underflow.
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue   = (fetch_ptr_q != wr_ptr) && (pending < 3'd2);

    always_comb begin
        fetch_ptr_d = fetch_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        inflight_d  = 1'b0;
        occ_d       = occ_q;
        head_d      = head_q;
        skid_d      = skid_q;
        if (flush) begin
            fetch_ptr_d = wr_ptr;
            rd_ptr_d    = wr_ptr;
            occ_d       = 2'd0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                fetch_ptr_d = fetch_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({pop, inflight_q})
                2'b01: begin
                    if (occ_q == 2'd0) begin
                        head_d = q_b;
                        occ_d  = 2'd1;
                    end else begin
                        skid_d = q_b;
                        occ_d  = 2'd2;
                    end
                end
                2'b10: begin
                    if (occ_q == 2'd2) begin
                        head_d = skid_q;
                    end
                    occ_d = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        head_d = skid_q;
                        skid_d = q_b;
                    end else begin
                        head_d = q_b;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_ptr_q <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            head_q      <= '0;
            skid_q      <= '0;
        end else begin
            fetch_ptr_q <= fetch_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model with 1-cycle registered read plus a scoreboard
// of written words checked against every stream handshake.
module tb_ram_stream_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  wr_ptr;
    logic        flush;
    logic [4:0]  address_b;
    logic [31:0] q_b;
    logic [5:0]  rd_ptr;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  level;
    logic        empty;

    logic [31:0] mem [32];
    logic [31:0] exp_q [$];
    logic [31:0] seq_data = 32'hC0DE0001;
    logic [5:0]  exp_rd = 6'd0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          pop_cnt = 0;

    ram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_ptr   (wr_ptr),
        .flush    (flush),
        .address_b(address_b),
        .q_b      (q_b),
        .rd_ptr   (rd_ptr),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .level    (level),
        .empty    (empty)
    );

    always #5 clock = ~clock;

    always @(posedge clock) q_b <= mem[address_b];

    // Scoreboard monitor: pointer tracking and in-order data check on each handshake.
    always @(negedge clock) begin
        if (!reset && !flush) begin
            n_checks++;
            if (rd_ptr !== exp_rd || level !== 6'(wr_ptr - exp_rd)) begin
                n_fail++;
                $display("FAIL ptr_track rd_ptr=%0h level=%0h expected rd_ptr=%0h level=%0h",
                         rd_ptr, level, exp_rd, 6'(wr_ptr - exp_rd));
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra got %h expected no word", out_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL stream_data got %h expected %h", out_data, e);
                    end
                end
                exp_rd = exp_rd + 6'd1;
                pop_cnt++;
            end
        end
    end

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[4:0]] = seq_data;
            exp_q.push_back(seq_data);
            seq_data = seq_data + 32'h01010101;
            wr_ptr = wr_ptr + 6'd1;
        end
    endtask

    task automatic wait_drain(input int max_cycles, output bit drained);
        drained = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !out_valid) begin
                drained = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        wr_ptr = 6'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_rd = 6'd0;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || rd_ptr !== 6'd0 ||
            address_b !== 5'd0 || level !== 6'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got v=%b d=%h rd=%h a=%h lvl=%h e=%b expected 0,0,0,0,0,1",
                     out_valid, out_data, rd_ptr, address_b, level, empty);
        end
    endtask

    task automatic test_single();
        logic [31:0] w;
        test_reset();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        w = seq_data;
        push_words(1);
        @(negedge clock);
        n_checks++;
        if (address_b !== 5'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c0 got addr=%h v=%b expected addr=0 v=0", address_b, out_valid);
        end
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c1 got v=%b expected 0", out_valid);
        end
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== w) begin
            n_fail++;
            $display("FAIL single_c2 got v=%b d=%h expected v=1 d=%h", out_valid, out_data, w);
        end
        @(negedge clock);
        n_checks++;
        if (rd_ptr !== 6'd1 || empty !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after got rd=%h e=%b v=%b expected rd=1 e=1 v=0",
                     rd_ptr, empty, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        test_reset();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        push_words(8);
        waited = 0;
        @(negedge clock);
        while (!out_valid && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_valid beat %0d got v=%b expected 1", i, out_valid);
            end
            @(negedge clock);
        end
        n_checks++;
        if (out_valid !== 1'b0 || rd_ptr !== 6'd8 || level !== 6'd0) begin
            n_fail++;
            $display("FAIL b2b_end got v=%b rd=%h lvl=%h expected v=0 rd=8 lvl=0",
                     out_valid, rd_ptr, level);
        end
    endtask

    task automatic test_backpressure();
        bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit          prev_hold = 1'b0;
        bit          done = 1'b0;
        logic [31:0] prev_data = '0;
        int          base;
        test_reset();
        base = pop_cnt;
        @(posedge clock);
        #1;
        push_words(8);
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clock);
            #1;
            out_ready = pat[i % 6];
            @(negedge clock);
            if (prev_hold) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL bp_stable got v=%b d=%h expected v=1 d=%h",
                             out_valid, out_data, prev_data);
                end
            end
            n_checks++;
            if (dut.occ_q > 2'd2) begin
                n_fail++;
                $display("FAIL bp_occ got %0d expected <=2", dut.occ_q);
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            done = (exp_q.size() == 0 && !out_valid);
        end
        n_checks++;
        if (!done || pop_cnt - base != 8) begin
            n_fail++;
            $display("FAIL bp_count got done=%b pops=%0d expected done=1 pops=8",
                     done, pop_cnt - base);
        end
    endtask

    task automatic test_wrap();
        bit         drained;
        bit         addr_wrap = 1'b0, rd_wrap1 = 1'b0, rd_wrap2 = 1'b0;
        logic [4:0] prev_addr = 5'd0;
        logic [5:0] prev_rd = 6'd0;
        test_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            push_words(20);
            drained = 1'b0;
            for (int i = 0; i < 60 && !drained; i++) begin
                @(negedge clock);
                if (prev_addr == 5'd31 && address_b == 5'd0) addr_wrap = 1'b1;
                if (prev_rd == 6'h1F && rd_ptr == 6'h20) rd_wrap1 = 1'b1;
                if (prev_rd == 6'h3F && rd_ptr == 6'h00) rd_wrap2 = 1'b1;
                prev_addr = address_b;
                prev_rd = rd_ptr;
                drained = (exp_q.size() == 0 && !out_valid);
            end
            n_checks++;
            if (!drained) begin
                n_fail++;
                $display("FAIL wrap_drain chunk %0d got undrained expected drained", c);
            end
        end
        n_checks++;
        if (!addr_wrap || !rd_wrap1 || !rd_wrap2 || rd_ptr !== 6'd16 || level !== 6'd0) begin
            n_fail++;
            $display("FAIL wrap_end got aw=%b r1=%b r2=%b rd=%h lvl=%h expected 1,1,1,10,0",
                     addr_wrap, rd_wrap1, rd_wrap2, rd_ptr, level);
        end
    endtask

    task automatic test_flush();
        bit drained;
        int base;
        test_reset();
        @(posedge clock);
        #1;
        push_words(6);
        repeat (4) @(posedge clock);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || dut.occ_q !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_pre got v=%b occ=%0d expected v=1 occ=2", out_valid, dut.occ_q);
        end
        out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        exp_q.delete();
        exp_rd = wr_ptr;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || rd_ptr !== 6'd6 || level !== 6'd0) begin
            n_fail++;
            $display("FAIL flush_post got v=%b rd=%h lvl=%h expected v=0 rd=6 lvl=0",
                     out_valid, rd_ptr, level);
        end
        base = pop_cnt;
        @(posedge clock);
        #1;
        push_words(1);
        wait_drain(12, drained);
        n_checks++;
        if (!drained || pop_cnt - base != 1) begin
            n_fail++;
            $display("FAIL flush_next got drained=%b pops=%0d expected 1,1",
                     drained, pop_cnt - base);
        end
    endtask

    task automatic test_reset_midstream();
        bit drained;
        int base;
        test_reset();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        push_words(10);
        repeat (4) @(posedge clock);
        #1;
        n_checks++;
        if (dut.inflight_q !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre got inflight=%b expected 1", dut.inflight_q);
        end
        reset = 1'b1;
        wr_ptr = 6'd0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_rd = 6'd0;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || rd_ptr !== 6'd0 || address_b !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_post got v=%b rd=%h a=%h expected 0,0,0",
                     out_valid, rd_ptr, address_b);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_stale got v=%b d=%h expected v=0", out_valid, out_data);
            end
        end
        base = pop_cnt;
        @(posedge clock);
        #1;
        push_words(1);
        wait_drain(12, drained);
        n_checks++;
        if (!drained || pop_cnt - base != 1) begin
            n_fail++;
            $display("FAIL rst_mid_next got drained=%b pops=%0d expected 1,1",
                     drained, pop_cnt - base);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_flush();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
